// File: rtl/apb_pkg.sv
// Shared APB responder definitions: default widths, register addresses and FSM states.
package apb_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 32;

    localparam logic [DEF_ADDR_WIDTH-1:0] DEF_CFG_ADDR  = 10'h300;
    localparam logic [DEF_ADDR_WIDTH-1:0] DEF_STAT_ADDR = 10'h304;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_resp_mem.sv
// Word array behind the responder: synchronous write, combinational read.
module apb_resp_mem #(
    parameter int WORDS = 192,
    parameter int DW    = 32,
    parameter int IW    = 8
) (
    input  logic          pclk,
    input  logic [IW-1:0] idx,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [WORDS];

    // Write at the closing edge; the top only raises we for in-range indices.
    always_ff @(posedge pclk) begin
        if (we) mem[idx] <= wdata;
    end

    // Out-of-range indices read as zero so the array is never over-indexed.
    assign rdata = (int'(idx) < WORDS) ? mem[idx] : '0;

endmodule

// File: rtl/apb_wait_responder.sv
// APB completer with programmable wait states, word memory, config and error-count registers.
module apb_wait_responder
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    MEM_WORDS  = 192,
    parameter logic [ADDR_WIDTH-1:0] CFG_ADDR   = DEF_CFG_ADDR,
    parameter logic [ADDR_WIDTH-1:0] STAT_ADDR  = DEF_STAT_ADDR,
    parameter logic [3:0]            WAIT_RST   = 4'd0
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  pselx,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam logic [IDX_W:0] MEM_LIM = (IDX_W + 1)'(MEM_WORDS);

    apb_state_t            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            wait_reg;
    logic [3:0]            cnt;
    logic [7:0]            err_cnt;

    logic                  setup;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  cur_wr;
    logic [IDX_W-1:0]      cur_idx;
    logic                  is_cfg, is_stat, in_mem, cur_err;
    logic [DATA_WIDTH-1:0] mem_rdata, rd_sel;
    logic                  closing, mem_we, respond;

    // Decode the setup-phase address when a new transfer starts, else the latched one,
    // so a zero-wait transfer can answer straight from the setup edge.
    always_comb begin
        setup    = pselx && !penable && (state != ACCESS);
        cur_addr = setup ? paddr : addr_q;
        cur_wr   = setup ? pwrite : wr_q;
        cur_idx  = cur_addr[ADDR_WIDTH-1:2];
        is_cfg   = (cur_addr == CFG_ADDR);
        is_stat  = (cur_addr == STAT_ADDR);
        in_mem   = ({1'b0, cur_idx} < MEM_LIM);
        cur_err  = (cur_addr[1:0] != 2'b00) || !(in_mem || is_cfg || is_stat) || (cur_wr && is_stat);
        if (is_cfg)       rd_sel = DATA_WIDTH'(wait_reg);
        else if (is_stat) rd_sel = DATA_WIDTH'(err_cnt);
        else              rd_sel = mem_rdata;
        closing  = (state == ACCESS) && pselx && pready;
        mem_we   = closing && wr_q && !cur_err && in_mem;
        respond  = (setup && wait_reg == 4'd0) ||
                   ((state == ACCESS) && pselx && !pready && cnt == 4'd1);
    end

    apb_resp_mem #(
        .WORDS (MEM_WORDS),
        .DW    (DATA_WIDTH),
        .IW    (IDX_W)
    ) u_mem (
        .pclk  (pclk),
        .idx   (cur_idx),
        .we    (mem_we),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    // Transfer FSM with registered response; responses default to zero every cycle.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state    <= IDLE;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            cnt      <= '0;
            wait_reg <= WAIT_RST;
            err_cnt  <= '0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            prdata   <= '0;
        end else begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            case (state)
                IDLE, DONE: begin
                    if (setup) begin
                        addr_q  <= paddr;
                        wr_q    <= pwrite;
                        wdata_q <= pwdata;
                        cnt     <= wait_reg;
                        state   <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (!pselx) begin
                        // Master abandoned the transfer: nothing is committed.
                        state <= IDLE;
                    end else if (pready) begin
                        state <= DONE;
                        if (cur_err) begin
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                        end else if (wr_q && is_cfg) begin
                            wait_reg <= wdata_q[3:0];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (respond) begin
                pready  <= 1'b1;
                pslverr <= cur_err;
                prdata  <= (cur_err || cur_wr) ? '0 : rd_sel;
            end
        end
    end

endmodule

// File: doc/apb_wait_responder.md
Name: apb_wait_responder

Overview:
- APB completer (responder) for the team's APB master.
- Decodes PADDR into a word memory plus two control/status registers.
- Inserts a programmable number of wait states and signals PSLVERR for illegal accesses.
- Used as the stress target for master verification: it exercises PREADY back-pressure and error paths that the zero-wait slave never drives.

Parameters:
ADDR_WIDTH, 10, PADDR width (byte address)
DATA_WIDTH, 32, PWDATA/PRDATA width
MEM_WORDS, 192, word-memory depth; occupies bytes 0x000 to 4*MEM_WORDS-1
CFG_ADDR, 10'h300, wait-state config register (R/W, bits [3:0])
STAT_ADDR, 10'h304, error-counter status register (read-only, bits [7:0])
WAIT_RST, 0, reset value of the wait-state register

Ports:
pclk  input  1  APB clock
presetn  input  1  reset; asynchronous, active-low
pselx  input  1  slave select
penable  input  1  access phase
pwrite  input  1  1 = write, 0 = read
paddr  input  ADDR_WIDTH  byte address
pwdata  input  DATA_WIDTH  write data
prdata  output  DATA_WIDTH  read data
pready  output  1  transfer complete
pslverr  output  1  transfer error, valid only with pready

Behaviour:
- Reset (async assert, sync release):
  - prdata=0, pready=0, pslverr=0.
  - wait_reg=WAIT_RST, err_cnt=0, FSM=IDLE.
  - Memory contents are not cleared and are undefined after power-up.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: on pselx=1, penable=0 (setup phase) at a clock edge:
  - Latch addr, wr, wdata.
  - Compute err = paddr[1:0]!=0, OR address unmapped, OR write to STAT_ADDR.
  - Load cnt=wait_reg. Go to ACCESS.
- ACCESS, entered while pselx=1 and penable=1:
  - cnt!=0: pready=0, cnt decrements.
  - cnt==0: registered pready=1 for exactly one cycle, then go to DONE.
- Timing: with wait value N, pready is high in access cycle N+1, so the transfer takes 2+N clocks including setup.
  - N=0 gives the standard 2-cycle transfer: pready is high in the first access cycle.
- Completing cycle (pready=1):
  - Write, no error: memory[addr>>2] or wait_reg is updated at the closing edge.
  - Read, no error: prdata = selected data; reads of CFG/STAT zero-extend.
  - Error: pslverr=1, prdata=0, no state write; err_cnt increments, saturating at 255.
- DONE: pready, pslverr and prdata return to 0.
  - If the next cycle is a setup phase (back-to-back transfer), handle it exactly as in IDLE.
  - Otherwise go to IDLE.
- Outside the completing cycle: pready=0, pslverr=0, prdata=0.
- Wait-register writes take effect from the next setup phase, never on the current transfer.
- Abort: if pselx drops while in ACCESS:
  - Return to IDLE, no write, no err_cnt change, pready stays 0.
- penable=1 seen in IDLE (protocol violation): ignored, no response.
- Reset mid-transfer: outputs go to reset values immediately; any pending write is discarded.
- Width rules:
  - Unmapped = word index >= MEM_WORDS and address not CFG_ADDR/STAT_ADDR.
  - wait_reg is 4 bits, so at most 15 wait states; writes keep pwdata[3:0] only.

Decomposition:
- Shared package apb_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH defaults.
  - CFG_ADDR and STAT_ADDR constants.
  - FSM state enum {IDLE, ACCESS, DONE}.
- One sub-module, apb_resp_mem: synchronous-write, combinational-read word array (MEM_WORDS x DATA_WIDTH) with write enable.
- Decode, FSM, wait counter and error counter stay in the top.

Test Plan:
- Reset, then read 0x300 with wait=0 -> pready in first access cycle, prdata=0x0, pslverr=0.
- Write 0x300=0x3, then write 0x010=0xDEADBEEF -> pready in access cycle 4 (3 waits); read 0x010 -> 0xDEADBEEF after 3 waits.
- Read 0x012 (misaligned), write 0x304, read 0x308 -> each gives pslverr=1 with pready, prdata=0; read 0x304 -> 0x3; memory unchanged.
- Drop pselx after 1 wait cycle during write 0x020=0x1 with wait=5 -> no pready, later read 0x020 returns the old value, err_cnt unchanged.
- Back-to-back writes 0x000=0x11, 0x004=0x22 with setup directly after pready (wait=0) -> both complete in 2 cycles each; reads return 0x11, 0x22.
- Assert presetn low mid-wait of write 0x030=0x55 -> pready/pslverr/prdata=0 immediately, wait_reg=WAIT_RST, no write to 0x030.
